spi_txn_arbiter: RTL and testbench

// Shares the single SPI master engine inside spi_wrapper between N_REQ transaction sources
// (e.g. Wishbone bridge, LA debug port). It arbitrates round-robin, issues one command per

---
 rtl/spi_txn_arbiter.sv | 128 ++++++++++++
 tb/tb_spi_txn_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// Round-robin owner of the single SPI master engine: one transaction in flight,
// timeout abort in WAIT, and an optional forced idle gap after every response.
module spi_txn_arbiter #(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 8,
  parameter int CS_W    = 2,
  parameter int TIMEOUT = 1023,
  parameter int GAP_CYC = 2
)(
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ*CS_W-1:0]   req_cs_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]       rsp_data_o,
  output logic                    rsp_err_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    spi_start_o,
  output logic [DATA_W-1:0]       spi_tx_o,
  output logic [CS_W-1:0]         spi_cs_o,
  input  logic                    spi_done_i,
  input  logic [DATA_W-1:0]       spi_rx_i
);
  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [PW-1:0] PTR_MAX  = PW'(N_REQ - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_q, own_q, win_idx;
  logic              win_vld;
  logic [DATA_W-1:0] tx_q, rx_q;
  logic [CS_W-1:0]   cs_q;
  logic              err_q;
  logic [TW-1:0]     tcnt_q;
  logic [GW-1:0]     gcnt_q;
  int                idx;

  // Scan from the highest offset down so the lowest offset from rr_q wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (req_valid_i[idx]) begin
        win_vld = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_vld) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (spi_done_i || tcnt_q == TO_LAST) state_d = S_RESP;
      S_RESP:  state_d = (GAP_CYC > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gcnt_q == GAP_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rr_q   <= '0;
      own_q  <= '0;
      tx_q   <= '0;
      cs_q   <= '0;
      rx_q   <= '0;
      err_q  <= 1'b0;
      tcnt_q <= '0;
      gcnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (win_vld) begin
          own_q <= win_idx;
          tx_q  <= req_data_i[int'(win_idx)*DATA_W +: DATA_W];
          cs_q  <= req_cs_i[int'(win_idx)*CS_W +: CS_W];
          rr_q  <= (win_idx == PTR_MAX) ? '0 : win_idx + 1'b1;
        end
        S_ISSUE: tcnt_q <= '0;
        S_WAIT: begin
          tcnt_q <= tcnt_q + 1'b1;
          // Completion takes priority over a timeout landing on the same cycle.
          if (spi_done_i) begin
            rx_q  <= spi_rx_i;
            err_q <= 1'b0;
          end else if (tcnt_q == TO_LAST) begin
            rx_q  <= '0;
            err_q <= 1'b1;
          end
        end
        S_RESP:  gcnt_q <= '0;
        S_GAP:   gcnt_q <= gcnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  logic [N_REQ-1:0] own_oh, win_oh;
  logic             busy_tx;
  assign own_oh  = N_REQ'(1) << own_q;
  assign win_oh  = N_REQ'(1) << win_idx;
  assign busy_tx = (state_q == S_ISSUE) || (state_q == S_WAIT);

  // Ready is combinational off the request inputs, so keep it quiet while reset is held.
  assign req_ready_o = (wb_rst_ni && state_q == S_IDLE && win_vld) ? win_oh : '0;
  assign grant_o     = (busy_tx || state_q == S_RESP) ? own_oh : '0;
  assign rsp_valid_o = (state_q == S_RESP) ? own_oh : '0;
  assign rsp_data_o  = (state_q == S_RESP) ? rx_q : '0;
  assign rsp_err_o   = (state_q == S_RESP) && err_q;
  assign spi_start_o = (state_q == S_ISSUE);
  assign spi_tx_o    = busy_tx ? tx_q : '0;
  assign spi_cs_o    = busy_tx ? cs_q : '0;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: dut_a (TIMEOUT=16, GAP_CYC=2) and dut_b (GAP_CYC=0).
module tb_spi_txn_arbiter;
  localparam int N = 2, DW = 8, CW = 2, TO = 16, GAP = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0, req_ready, rsp_valid, grant;
  logic [N*DW-1:0] req_data = '0;
  logic [N*CW-1:0] req_cs = '0;
  logic [DW-1:0]   rsp_data, spi_tx, spi_rx = '0;
  logic [CW-1:0]   spi_cs;
  logic            rsp_err, spi_start, spi_done = 1'b0;

  logic [N-1:0]    b_valid = '0, b_ready, b_rsp_valid, b_grant;
  logic [DW-1:0]   b_rsp_data, b_tx;
  logic [CW-1:0]   b_cs;
  logic            b_err, b_start, b_done = 1'b0;

  spi_txn_arbiter #(.N_REQ(N), .DATA_W(DW), .CS_W(CW), .TIMEOUT(TO), .GAP_CYC(GAP)) dut_a (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_data_i(req_data), .req_cs_i(req_cs), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .grant_o(grant), .spi_start_o(spi_start), .spi_tx_o(spi_tx),
    .spi_cs_o(spi_cs), .spi_done_i(spi_done), .spi_rx_i(spi_rx));

  spi_txn_arbiter #(.N_REQ(N), .DATA_W(DW), .CS_W(CW), .TIMEOUT(1023), .GAP_CYC(0)) dut_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_data_i(req_data), .req_cs_i(req_cs), .rsp_valid_o(b_rsp_valid), .rsp_data_o(b_rsp_data),
    .rsp_err_o(b_err), .grant_o(b_grant), .spi_start_o(b_start), .spi_tx_o(b_tx),
    .spi_cs_o(b_cs), .spi_done_i(b_done), .spi_rx_i(spi_rx));

  typedef struct {
    logic [1:0] valid; logic [7:0] d0; logic [1:0] cs0; logic done; logic [7:0] rx;
    logic [1:0] e_ready; logic e_start; logic [1:0] e_grant; logic [1:0] e_rsp;
    logic [7:0] e_data; logic e_err; logic tx_chk; logic [7:0] e_tx; logic [1:0] e_cs;
  } vec_t;

  vec_t tv[$];
  int   n_chk = 0, n_fail = 0;
  int   s, r, sb, rb, nr, ng, owner, last_rsp;
  int   gw[4];
  logic [7:0] exp_rx, exp_tx;

  function automatic vec_t mk(logic [1:0] v, logic [7:0] d, logic [1:0] c, logic dn, logic [7:0] rx,
                              logic [1:0] rdy, logic st, logic [1:0] g, logic [1:0] rv,
                              logic [7:0] dat, logic er, logic tc, logic [7:0] tx, logic [1:0] cs);
    vec_t t;
    t.valid = v; t.d0 = d; t.cs0 = c; t.done = dn; t.rx = rx;
    t.e_ready = rdy; t.e_start = st; t.e_grant = g; t.e_rsp = rv;
    t.e_data = dat; t.e_err = er; t.tx_chk = tc; t.e_tx = tx; t.e_cs = cs;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reset is held for one cycle with requests pending so ready gating is visible.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 2'b11; b_valid = 2'b11; spi_done = 1'b0; b_done = 1'b0;
    #1;
    chk("rst.ready", req_ready, 0);   chk("rst.grant", grant, 0);
    chk("rst.start", spi_start, 0);   chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_data", rsp_data, 0); chk("rst.rsp_err", rsp_err, 0);
    chk("rst.tx", spi_tx, 0);         chk("rst.cs", spi_cs, 0);
    chk("rst.b_ready", b_ready, 0);
    @(negedge clk);
    req_valid = '0; b_valid = '0; rst_n = 1'b1;
  endtask

  initial begin
    // Single request: handshake, start, 8-cycle engine, response, gap, next grant.
    tv.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0));
    tv.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0));
    tv.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 8'hA5, 1));
    for (int i = 0; i < 7; i++)
      tv.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, 8'hA5, 1));
    tv.push_back(mk(0, 8'h00, 0, 1, 8'h3C, 0, 0, 1, 0, 8'h00, 0, 1, 8'hA5, 1));
    tv.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 1, 8'h3C, 0, 0, 8'h00, 0));
    tv.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0));
    tv.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0));
    tv.push_back(mk(1, 8'h5A, 2, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0));
    tv.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 8'h5A, 2));

    do_reset();
    foreach (tv[i]) begin
      req_valid = tv[i].valid; req_data = {8'h00, tv[i].d0}; req_cs = {2'b00, tv[i].cs0};
      spi_done = tv[i].done; spi_rx = tv[i].rx;
      #1;
      chk($sformatf("t1[%0d].ready", i), req_ready, tv[i].e_ready);
      chk($sformatf("t1[%0d].start", i), spi_start, tv[i].e_start);
      chk($sformatf("t1[%0d].grant", i), grant, tv[i].e_grant);
      chk($sformatf("t1[%0d].rsp_valid", i), rsp_valid, tv[i].e_rsp);
      if (tv[i].e_rsp != 0) begin
        chk($sformatf("t1[%0d].rsp_data", i), rsp_data, tv[i].e_data);
        chk($sformatf("t1[%0d].rsp_err", i), rsp_err, tv[i].e_err);
      end
      if (tv[i].tx_chk) begin
        chk($sformatf("t1[%0d].tx", i), spi_tx, tv[i].e_tx);
        chk($sformatf("t1[%0d].cs", i), spi_cs, tv[i].e_cs);
      end
      @(negedge clk);
    end

    // Round-robin with both requesters held valid; engine answers 2 cycles after start.
    do_reset();
    req_valid = 2'b11; req_data = {8'hB2, 8'hB1}; req_cs = {2'd2, 2'd1};
    ng = 0; s = -100; last_rsp = -1; owner = 0; exp_rx = '0;
    for (int c = 0; c < 200 && ng < 4; c++) begin
      spi_done = (c == s + 2); spi_rx = 8'h40 + 8'(c);
      if (spi_done) exp_rx = spi_rx;
      #1;
      if (spi_start) begin
        s = c;
        chk("t2.tx", spi_tx, owner ? 8'hB2 : 8'hB1);
      end
      if (rsp_valid != 0) begin
        last_rsp = c;
        chk("t2.rsp_owner", rsp_valid, owner ? 2'b10 : 2'b01);
        chk("t2.rsp_data", rsp_data, exp_rx);
      end
      if (req_ready != 0) begin
        owner = (req_ready == 2'b10) ? 1 : 0;
        gw[ng] = owner;
        if (ng > 0) chk("t2.spacing", c - last_rsp, GAP + 1);
        ng++;
      end
      @(negedge clk);
    end
    spi_done = 1'b0; req_valid = '0;
    chk("t2.grants", ng, 4);
    chk("t2.order", {gw[0][1:0], gw[1][1:0], gw[2][1:0], gw[3][1:0]}, 8'b00_01_00_01);

    // Timeout with no done, then late done pulses that must be ignored.
    do_reset();
    s = -1; r = -1;
    for (int c = 0; c < 60; c++) begin
      req_valid = (c == 0) ? 2'b01 : 2'b00; req_data = {8'h00, 8'h11};
      spi_done = (r >= 0 && (c == r + 1 || c == r + 5)); spi_rx = 8'hEE;
      #1;
      if (spi_start) s = c;
      if (r >= 0 && c > r && c <= r + 8) chk("t3.late_rsp", rsp_valid, 0);
      if (rsp_valid != 0 && r < 0) begin
        r = c;
        chk("t3.latency", c - s - 1, TO);
        chk("t3.err", rsp_err, 1);
        chk("t3.data", rsp_data, 0);
        chk("t3.owner", rsp_valid, 2'b01);
      end
      @(negedge clk);
    end
    spi_done = 1'b0;
    chk("t3.seen", r >= 0, 1);

    // Done on the final WAIT cycle wins over the timeout.
    do_reset();
    s = -100; r = -1;
    for (int c = 0; c < 40 && r < 0; c++) begin
      req_valid = (c == 0) ? 2'b01 : 2'b00; req_data = {8'h00, 8'h22};
      spi_done = (c == s + TO); spi_rx = 8'h77;
      #1;
      if (spi_start) s = c;
      if (rsp_valid != 0) begin
        r = c;
        chk("t4.latency", c - s, TO + 1);
        chk("t4.err", rsp_err, 0);
        chk("t4.data", rsp_data, 8'h77);
      end
      @(negedge clk);
    end
    spi_done = 1'b0;
    chk("t4.seen", r >= 0, 1);

    // Reset while in WAIT, then req1 alone is granted.
    do_reset();
    req_data = {8'h99, 8'h55};
    for (int c = 0; c < 4; c++) begin
      req_valid = (c == 0) ? 2'b01 : 2'b00;
      #1;
      if (c == 0) chk("t5.ready0", req_ready, 2'b01);
      if (c == 3) chk("t5.in_wait", grant, 2'b01);
      @(negedge clk);
    end
    rst_n = 1'b0; req_valid = 2'b10;
    #1;
    chk("t5.ready", req_ready, 0);   chk("t5.grant", grant, 0);
    chk("t5.start", spi_start, 0);   chk("t5.rsp_valid", rsp_valid, 0);
    chk("t5.tx", spi_tx, 0);         chk("t5.cs", spi_cs, 0);
    @(negedge clk); #1;
    chk("t5.rsp_in_rst", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5.ready1", req_ready, 2'b10);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t5.grant1", grant, 2'b10); chk("t5.start1", spi_start, 1); chk("t5.tx1", spi_tx, 8'h99);
    @(negedge clk);
    spi_done = 1'b1; spi_rx = 8'h21;
    #1;
    chk("t5.no_rsp", rsp_valid, 0);
    @(negedge clk);
    spi_done = 1'b0;
    #1;
    chk("t5.rsp1", rsp_valid, 2'b10); chk("t5.rsp1_data", rsp_data, 8'h21);
    @(negedge clk);

    // GAP_CYC=0 build: ready returns exactly one cycle after the response.
    do_reset();
    b_valid = 2'b01; req_data = {8'h00, 8'h6B};
    sb = -100; rb = -1; nr = 0;
    for (int c = 0; c < 100 && nr < 2; c++) begin
      b_done = (c == sb + 2); spi_rx = 8'h0F;
      #1;
      if (b_start) sb = c;
      if (rb >= 0 && c == rb + 1) begin
        chk("t6.ready_next", b_ready, 2'b01);
        chk("t6.grant_idle", b_grant, 0);
        nr++;
      end
      if (b_rsp_valid != 0) begin
        rb = c;
        chk("t6.ready_in_resp", b_ready, 0);
        chk("t6.rsp_data", b_rsp_data, 8'h0F);
      end
      @(negedge clk);
    end
    b_done = 1'b0; b_valid = '0;
    chk("t6.count", nr, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
